// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: controller
// states and the helpers that size the digit counter.
package addsub_pkg;

  // Controller states. RUN consumes one digit per clock; DONE is the single
  // cycle in which the registered result is flagged valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digits an operand is split into.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width. It never drops below one bit, so NDIG == 1 still
  // gets a real counter.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder. It is the only arithmetic in
// the serial unit and is reused on every clock of an operation.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co
);

  logic carry;

  // Ripple the carry from the least-significant bit upwards.
  always_comb begin
    carry = ci;
    sum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. An operation is split into NDIG digits of
// DIGIT bits, one digit per clock through a single digit_adder.
//
// Handshake: start is a request that is sampled only while the unit can
// accept (IDLE or DONE); a request seen on such an edge is accepted on that
// edge and the operands, sub and cin are captured there. busy is high for
// exactly NDIG cycles after the accept edge, then done pulses for one cycle
// while s/cout/ovf hold the new result. start during busy is dropped, not
// queued. Holding start through the done cycle chains the next operation
// with no idle gap.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  // Reject geometries the digit slicing cannot represent.
  if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t state_q, state_d;

  // Operands are shifted right one digit per clock so the digit being
  // worked on is always at the bottom. b_q already holds b or ~b.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic [WIDTH-1:0] res_next;
  logic             accept;
  logic             last_digit;

  assign accept     = start && (state_q != RUN);
  assign last_digit = (state_q == RUN) && (cnt_q == LAST_CNT);

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .ci (carry_q),
    .sum(dsum),
    .co (dco)
  );

  // Partial result assembly. With a single digit the adder output is the
  // whole result; otherwise earlier digits collect in a shift register whose
  // newest digit enters at the top, so after NDIG-1 shifts the final digit
  // completes the word.
  if (NDIG == 1) begin : g_single
    assign res_next = dsum;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] part_q;

    assign res_next = {dsum, part_q};

    // Shift each finished digit into the partial-result register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        part_q <= '0;
      end else if (state_q == RUN) begin
        part_q <= res_next[WIDTH-1:DIGIT];
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept from IDLE or DONE, leave RUN after the last digit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_digit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-digit datapath update and final result transfer.
  // Subtraction is folded into the capture: b is inverted and the borrow-in
  // becomes an inverted carry-in, so RUN only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? ~cin : cin;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      carry_q <= dco;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        s    <= res_next;
        cout <= dco;
        // Overflow: like-signed addends giving a result of the other sign.
        ovf  <= (a_msb_q == b_msb_q) && (dsum[DIGIT-1] != a_msb_q);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a 4-bit/1-bit-digit instance and an
// 8-bit/4-bit-digit instance, checked against an integer arithmetic model.
module tb_serial_addsub;

  logic clk;
  logic rst_n;

  // 4-bit, one bit per clock
  logic       start4, sub4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] s4;
  logic [1:0] dbg4;

  // 8-bit, four bits per clock
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;
  logic [1:0] dbg8;

  int checks = 0;
  int errors = 0;

  // Expected results {ovf, cout, s[7:0]}
  logic [9:0] exp4_q[$];
  logic [9:0] exp8_q[$];
  logic [9:0] last4;
  logic [9:0] last8;

  serial_addsub #(.WIDTH(4), .DIGIT(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .s(s4), .cout(cout4),
    .ovf(ovf4), .dbg_state(dbg4)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .s(s8), .cout(cout8),
    .ovf(ovf8), .dbg_state(dbg8)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic at width w.
  function automatic logic [9:0] model(input int w, input logic sb, input logic [7:0] a,
                                       input logic [7:0] b, input logic c);
    longint mask, ua, ub, tot, sa, sbv, r, hi, lo, sres, cres;
    logic [9:0] res;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (sb) tot = ua + ((~ub) & mask) + (c ? 0 : 1);
    else    tot = ua + ub + longint'(c);
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sbv  = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    r    = sb ? sa - sbv - longint'(c) : sa + sbv + longint'(c);
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    sres = tot & mask;
    cres = (tot >> w) & 1;
    res      = '0;
    res[7:0] = sres[7:0];
    res[8]   = cres[0];
    res[9]   = (r > hi) || (r < lo);
    return res;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (done4) begin
      check("busy4_with_done", busy4, 0);
      if (exp4_q.size() == 0) begin
        check("spurious_done4", done4, 0);
      end else begin
        logic [9:0] e;
        e = exp4_q.pop_front();
        check("s4", s4, e[3:0]);
        check("cout4", cout4, e[8]);
        check("ovf4", ovf4, e[9]);
        last4 = e;
      end
    end
    if (done8) begin
      check("busy8_with_done", busy8, 0);
      if (exp8_q.size() == 0) begin
        check("spurious_done8", done8, 0);
      end else begin
        logic [9:0] e;
        e = exp8_q.pop_front();
        check("s8", s8, e[7:0]);
        check("cout8", cout8, e[8]);
        check("ovf8", ovf8, e[9]);
        last8 = e;
      end
    end
  end

  // ---------------- drivers ----------------
  // One 4-bit operation. b2b: request during the current (DONE) cycle.
  // poke: pulse start with other operands mid-RUN, which must be ignored.
  task automatic op4(input logic sb, input logic [3:0] a, input logic [3:0] b,
                     input logic c, input bit b2b, input bit poke);
    if (!b2b) @(negedge clk);
    start4 = 1'b1; sub4 = sb; a4 = a; b4 = b; cin4 = c;
    exp4_q.push_back(model(4, sb, {4'h0, a}, {4'h0, b}, c));
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom); cin4 = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      check("busy4_run", busy4, 1);
      check("done4_early", done4, 0);
      check("hold_s4", s4, last4[3:0]);
      if (poke && i == 1) begin
        start4 = 1'b1; a4 = ~a; b4 = ~b; sub4 = ~sb;
      end else begin
        start4 = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    check("done4_pulse", done4, 1);
    check("pending4", exp4_q.size(), 0);
  endtask

  task automatic op8(input logic sb, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input bit b2b);
    if (!b2b) @(negedge clk);
    start8 = 1'b1; sub8 = sb; a8 = a; b8 = b; cin8 = c;
    exp8_q.push_back(model(8, sb, a, b, c));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      check("busy8_run", busy8, 1);
      check("done8_early", done8, 0);
      check("hold_s8", s8, last8[7:0]);
      @(negedge clk);
    end
    #1;
    check("done8_pulse", done8, 1);
    check("pending8", exp8_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    last4 = '0; last8 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_s4", s4, 0);
    check("rst_cout4", cout4, 0);
    check("rst_ovf4", ovf4, 0);
    check("rst_busy8", busy8, 0);
    check("rst_s8", s8, 0);
    rst_n = 1'b1;

    // Directed cases
    op4(0, 4'b0101, 4'b0110, 0, 0, 0);
    op4(0, 4'b1001, 4'b0111, 1, 0, 0);
    op4(1, 4'b0101, 4'b0110, 0, 0, 0);
    op4(1, 4'b1001, 4'b0111, 1, 0, 0);
    op8(0, 8'h7F, 8'h01, 0, 0);
    op8(0, 8'hFF, 8'h01, 0, 1);

    // start mid-RUN ignored
    op4(0, 4'b0011, 4'b0100, 0, 0, 1);
    @(negedge clk);
    check("idle_after_poke", busy4, 0);

    // Reset mid-RUN
    @(negedge clk);
    start4 = 1'b1; sub4 = 0; a4 = 4'hA; b4 = 4'h3; cin4 = 0;
    @(negedge clk);
    start4 = 1'b0;
    check("abort_busy_before", busy4, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy4", busy4, 0);
    check("abort_done4", done4, 0);
    check("abort_s4", s4, 0);
    check("abort_cout4", cout4, 0);
    check("abort_ovf4", ovf4, 0);
    check("abort_s8", s8, 0);
    last4 = '0; last8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_rst", done4, 0);
    end

    // Normal operation after reset
    op4(0, 4'b0010, 4'b0011, 1, 0, 0);

    // Randomized operations
    for (int i = 0; i < 25; i++) begin
      op4(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 25; i++) begin
      op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 1));
    end

    repeat (4) @(negedge clk);
    check("final_q4", exp4_q.size(), 0);
    check("final_q8", exp8_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
